// File: rtl/id_hazard_ctrl.sv
// Decode-stage interlock controller: load-use scoreboard, redirect flush sequencing, stall watchdog.
// Optional stall-cycle performance counter is built when HAZ_PERF_EN is defined.
module id_hazard_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int NUM_REGS  = 32,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int STALL_MAX = 15
) (
  input  logic                p_clk,
  input  logic                p_reset,
  input  logic                p_id_valid,
  input  logic [ADDR_W-1:0]   p_id_rs,
  input  logic                p_id_rs_used,
  input  logic [ADDR_W-1:0]   p_id_rt,
  input  logic                p_id_rt_used,
  input  logic [ADDR_W-1:0]   p_id_dest,
  input  logic                p_id_is_load,
  input  logic                p_ex_redirect,
  input  logic                p_wb_we,
  input  logic [ADDR_W-1:0]   p_wb_addr,
  output logic                p_stall,
  output logic                p_bubble,
  output logic                p_flush,
  output logic                p_issue,
  output logic [NUM_REGS-1:0] p_busy_mask,
  output logic                p_err,
  output logic [31:0]         p_stall_cnt
);

  localparam int WD_W = $clog2(STALL_MAX + 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t              state, state_nxt;
  logic [2:0]          fcnt, fcnt_nxt;
  logic [2:0]          cnt [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic                flushing;
  logic                hazard;
  logic [WD_W-1:0]     run_cnt;

  always_comb begin
    pending = '0;
    for (int r = 1; r < NUM_REGS; r++) pending[r] = (cnt[r] != 3'd0);
  end

  assign flushing = (state == ST_FLUSH);
  assign hazard   = p_id_valid & ((p_id_rs_used & pending[p_id_rs]) |
                                  (p_id_rt_used & pending[p_id_rt]));

  // Handshake: ID offers an instruction with p_id_valid and it transfers in exactly the
  // cycles where p_issue=1; otherwise ID holds it (stall) or it is discarded (flush/redirect).
  assign p_stall     = hazard & ~flushing & ~p_ex_redirect;
  assign p_bubble    = p_stall | flushing | p_ex_redirect;
  assign p_issue     = p_id_valid & ~p_bubble;
  assign p_flush     = flushing;
  assign p_busy_mask = pending;

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= 3'd0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r != 0 && p_issue && p_id_is_load && p_id_dest == ADDR_W'(r))
          cnt[r] <= 3'(LOAD_LAT);
        else if (p_wb_we && p_wb_addr == ADDR_W'(r))
          cnt[r] <= 3'd0;
        else if (cnt[r] != 3'd0)
          cnt[r] <= cnt[r] - 3'd1;
      end
    end
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state <= ST_RUN;
      fcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      ST_RUN: begin
        if (p_ex_redirect) begin
          state_nxt = ST_FLUSH;
          fcnt_nxt  = 3'(FLUSH_CYC);
        end
      end
      ST_FLUSH: begin
        if (p_ex_redirect) begin
          fcnt_nxt = 3'(FLUSH_CYC);
        end else if (fcnt <= 3'd1) begin
          state_nxt = ST_RUN;
          fcnt_nxt  = 3'd0;
        end else begin
          fcnt_nxt = fcnt - 3'd1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        fcnt_nxt  = 3'd0;
      end
    endcase
  end

  // run_cnt holds the stalls before this cycle, so the STALL_MAX-th stall sets p_err.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      run_cnt <= '0;
      p_err   <= 1'b0;
    end else if (p_stall) begin
      if (run_cnt >= WD_W'(STALL_MAX - 1)) p_err <= 1'b1;
      if (run_cnt != WD_W'(STALL_MAX)) run_cnt <= run_cnt + 1'b1;
    end else begin
      run_cnt <= '0;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge p_clk) begin
    if (p_reset)
      stall_cnt_q <= 32'd0;
    else if (p_stall && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign p_stall_cnt = stall_cnt_q;
`else
  assign p_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: three parameterisations share stimulus; a cycle-time reference
// model checks every cycle, plus a vector table and directed multi-cycle sequences.
module tb_id_hazard_ctrl;

  logic       p_clk;
  logic       p_reset;
  logic       p_id_valid;
  logic [4:0] p_id_rs;
  logic       p_id_rs_used;
  logic [4:0] p_id_rt;
  logic       p_id_rt_used;
  logic [4:0] p_id_dest;
  logic       p_id_is_load;
  logic       p_ex_redirect;
  logic       p_wb_we;
  logic [4:0] p_wb_addr;

  logic        stall_o  [3];
  logic        bubble_o [3];
  logic        flush_o  [3];
  logic        issue_o  [3];
  logic [31:0] busy_o   [3];
  logic        err_o    [3];
  logic [31:0] stcnt_o  [3];

`ifdef HAZ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  id_hazard_ctrl #(.LOAD_LAT(1), .FLUSH_CYC(1), .STALL_MAX(15)) dut0 (
    .p_clk(p_clk), .p_reset(p_reset), .p_id_valid(p_id_valid), .p_id_rs(p_id_rs),
    .p_id_rs_used(p_id_rs_used), .p_id_rt(p_id_rt), .p_id_rt_used(p_id_rt_used),
    .p_id_dest(p_id_dest), .p_id_is_load(p_id_is_load), .p_ex_redirect(p_ex_redirect),
    .p_wb_we(p_wb_we), .p_wb_addr(p_wb_addr), .p_stall(stall_o[0]), .p_bubble(bubble_o[0]),
    .p_flush(flush_o[0]), .p_issue(issue_o[0]), .p_busy_mask(busy_o[0]), .p_err(err_o[0]),
    .p_stall_cnt(stcnt_o[0]));

  id_hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYC(3), .STALL_MAX(15)) dut1 (
    .p_clk(p_clk), .p_reset(p_reset), .p_id_valid(p_id_valid), .p_id_rs(p_id_rs),
    .p_id_rs_used(p_id_rs_used), .p_id_rt(p_id_rt), .p_id_rt_used(p_id_rt_used),
    .p_id_dest(p_id_dest), .p_id_is_load(p_id_is_load), .p_ex_redirect(p_ex_redirect),
    .p_wb_we(p_wb_we), .p_wb_addr(p_wb_addr), .p_stall(stall_o[1]), .p_bubble(bubble_o[1]),
    .p_flush(flush_o[1]), .p_issue(issue_o[1]), .p_busy_mask(busy_o[1]), .p_err(err_o[1]),
    .p_stall_cnt(stcnt_o[1]));

  id_hazard_ctrl #(.LOAD_LAT(7), .FLUSH_CYC(2), .STALL_MAX(4)) dut2 (
    .p_clk(p_clk), .p_reset(p_reset), .p_id_valid(p_id_valid), .p_id_rs(p_id_rs),
    .p_id_rs_used(p_id_rs_used), .p_id_rt(p_id_rt), .p_id_rt_used(p_id_rt_used),
    .p_id_dest(p_id_dest), .p_id_is_load(p_id_is_load), .p_ex_redirect(p_ex_redirect),
    .p_wb_we(p_wb_we), .p_wb_addr(p_wb_addr), .p_stall(stall_o[2]), .p_bubble(bubble_o[2]),
    .p_flush(flush_o[2]), .p_issue(issue_o[2]), .p_busy_mask(busy_o[2]), .p_err(err_o[2]),
    .p_stall_cnt(stcnt_o[2]));

  // clock / reset
  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  function automatic int lat_of(int k);
    case (k) 0: return 1; 1: return 3; default: return 7; endcase
  endfunction
  function automatic int fl_of(int k);
    case (k) 0: return 1; 1: return 3; default: return 2; endcase
  endfunction
  function automatic int sm_of(int k);
    case (k) 0: return 15; 1: return 15; default: return 4; endcase
  endfunction

  // Reference model: a register is pending until an absolute cycle number, flushing
  // until another; everything else follows directly from the interlock rules.
  int     cyc;
  int     ready_at  [3][32];
  int     flush_end [3];
  int     run       [3];
  bit     m_err     [3];
  longint m_stalls  [3];
  logic        m_stall [3], m_bubble [3], m_flush [3], m_issue [3];
  logic [31:0] m_busy  [3];

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
      flush_end[k] = 0;
      run[k]       = 0;
      m_err[k]     = 1'b0;
      m_stalls[k]  = 0;
    end
  endtask

  task automatic model_eval();
    logic hz;
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = '0;
      for (int r = 1; r < 32; r++) m_busy[k][r] = (cyc < ready_at[k][r]);
      m_flush[k]  = (cyc < flush_end[k]);
      hz = p_id_valid && ((p_id_rs_used && m_busy[k][p_id_rs]) ||
                          (p_id_rt_used && m_busy[k][p_id_rt]));
      m_stall[k]  = hz && !m_flush[k] && !p_ex_redirect;
      m_bubble[k] = m_stall[k] || m_flush[k] || p_ex_redirect;
      m_issue[k]  = p_id_valid && !m_bubble[k];
    end
  endtask

  task automatic model_update();
    bit set_ld;
    if (p_reset) begin
      model_clear();
    end else begin
      for (int k = 0; k < 3; k++) begin
        set_ld = m_issue[k] && p_id_is_load && (p_id_dest != 5'd0);
        if (set_ld) ready_at[k][p_id_dest] = cyc + 1 + lat_of(k);
        if (p_wb_we && !(set_ld && p_id_dest == p_wb_addr) && ready_at[k][p_wb_addr] > cyc + 1)
          ready_at[k][p_wb_addr] = cyc + 1;
        if (p_ex_redirect) flush_end[k] = cyc + 1 + fl_of(k);
        if (m_stall[k]) begin
          run[k]++;
          if (run[k] >= sm_of(k)) m_err[k] = 1'b1;
          m_stalls[k]++;
        end else begin
          run[k] = 0;
        end
      end
    end
    cyc++;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cycle %0d: got %h, expected %h", name, k, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    logic [31:0] exp_cnt;
    for (int k = 0; k < 3; k++) begin
      exp_cnt = 32'd0;
      if (PERF) exp_cnt = (m_stalls[k] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_stalls[k][31:0];
      chk("m_stall",  k, 32'(stall_o[k]),  32'(m_stall[k]));
      chk("m_bubble", k, 32'(bubble_o[k]), 32'(m_bubble[k]));
      chk("m_flush",  k, 32'(flush_o[k]),  32'(m_flush[k]));
      chk("m_issue",  k, 32'(issue_o[k]),  32'(m_issue[k]));
      chk("m_busy",   k, busy_o[k],        m_busy[k]);
      chk("m_err",    k, 32'(err_o[k]),    32'(m_err[k]));
      chk("m_stcnt",  k, stcnt_o[k],       exp_cnt);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                       input logic rtu, input logic [4:0] dest, input logic ld, input logic redir,
                       input logic wbwe, input logic [4:0] wba);
    p_id_valid = v;   p_id_rs = rs;      p_id_rs_used = rsu;
    p_id_rt = rt;     p_id_rt_used = rtu; p_id_dest = dest;
    p_id_is_load = ld; p_ex_redirect = redir; p_wb_we = wbwe; p_wb_addr = wba;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic sample();
    @(negedge p_clk);
    model_eval();
    model_check();
  endtask

  task automatic tick();
    model_update();
    @(posedge p_clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    p_reset = 1'b1;
    sample();
    tick();
    p_reset = 1'b0;
  endtask

  typedef struct {
    logic v; logic [4:0] rs; logic rsu; logic [4:0] rt; logic rtu; logic [4:0] dest;
    logic ld; logic redir; logic wbwe; logic [4:0] wba;
    logic e_stall; logic e_bubble; logic e_flush; logic e_issue; logic [31:0] e_busy;
  } vec_t;

  function automatic vec_t mk(logic v, logic [4:0] rs, logic rsu, logic [4:0] rt, logic rtu,
                              logic [4:0] dest, logic ld, logic redir, logic wbwe, logic [4:0] wba,
                              logic es, logic eb, logic ef, logic ei, logic [31:0] ebusy);
    vec_t t;
    t.v = v; t.rs = rs; t.rsu = rsu; t.rt = rt; t.rtu = rtu; t.dest = dest; t.ld = ld;
    t.redir = redir; t.wbwe = wbwe; t.wba = wba;
    t.e_stall = es; t.e_bubble = eb; t.e_flush = ef; t.e_issue = ei; t.e_busy = ebusy;
    return t;
  endfunction

  vec_t tbl [15];

  initial begin
    // Expected values are for dut0 (LOAD_LAT=1, FLUSH_CYC=1).
    tbl[0]  = mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0,  0, 0, 0, 1, 32'h0);   // load r5
    tbl[1]  = mk(1, 5, 1, 2, 1, 6, 0, 0, 0, 0,  1, 1, 0, 0, 32'h20);  // use r5 -> stall
    tbl[2]  = mk(1, 5, 1, 2, 1, 6, 0, 0, 0, 0,  0, 0, 0, 1, 32'h0);   // then issue
    tbl[3]  = mk(1, 1, 1, 2, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 32'h0);   // load r0
    tbl[4]  = mk(1, 0, 1, 0, 1, 3, 0, 0, 0, 0,  0, 0, 0, 1, 32'h0);   // use r0
    tbl[5]  = mk(1, 1, 1, 0, 0, 5, 1, 0, 0, 0,  0, 0, 0, 1, 32'h0);   // load r5
    tbl[6]  = mk(1, 2, 1, 5, 0, 4, 0, 0, 0, 0,  0, 0, 0, 1, 32'h20);  // rt=r5 unused
    tbl[7]  = mk(1, 1, 1, 0, 0, 5, 1, 0, 0, 0,  0, 0, 0, 1, 32'h0);   // load r5
    tbl[8]  = mk(1, 5, 1, 0, 0, 6, 0, 1, 0, 0,  0, 1, 0, 0, 32'h20);  // hazard + redirect
    tbl[9]  = mk(1, 3, 1, 0, 0, 6, 0, 0, 0, 0,  0, 1, 1, 0, 32'h0);   // flushing
    tbl[10] = mk(1, 3, 1, 0, 0, 6, 0, 0, 0, 0,  0, 0, 0, 1, 32'h0);   // back to run
    tbl[11] = mk(1, 1, 1, 0, 0, 6, 1, 0, 1, 6,  0, 0, 0, 1, 32'h0);   // load r6 + wb r6
    tbl[12] = mk(1, 6, 1, 0, 0, 7, 0, 0, 0, 0,  1, 1, 0, 0, 32'h40);  // issue won over wb
    tbl[13] = mk(1, 6, 1, 0, 0, 7, 0, 0, 0, 0,  0, 0, 0, 1, 32'h0);
    tbl[14] = mk(0, 6, 1, 0, 0, 7, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0);   // no valid

    idle();
    p_reset = 1'b1;
    repeat (3) @(posedge p_clk);
    #1;
    cyc = 0;
    model_clear();
    p_reset = 1'b0;

    // reset state
    sample();
    for (int k = 0; k < 3; k++) begin
      chk("rst_stall", k, 32'(stall_o[k]), 32'd0);
      chk("rst_bubble", k, 32'(bubble_o[k]), 32'd0);
      chk("rst_flush", k, 32'(flush_o[k]), 32'd0);
      chk("rst_busy", k, busy_o[k], 32'd0);
      chk("rst_err", k, 32'(err_o[k]), 32'd0);
      chk("rst_stcnt", k, stcnt_o[k], 32'd0);
    end
    tick();

    // vector table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].rs, tbl[i].rsu, tbl[i].rt, tbl[i].rtu, tbl[i].dest, tbl[i].ld,
            tbl[i].redir, tbl[i].wbwe, tbl[i].wba);
      sample();
      chk($sformatf("tbl%0d_stall", i),  0, 32'(stall_o[0]),  32'(tbl[i].e_stall));
      chk($sformatf("tbl%0d_bubble", i), 0, 32'(bubble_o[0]), 32'(tbl[i].e_bubble));
      chk($sformatf("tbl%0d_flush", i),  0, 32'(flush_o[0]),  32'(tbl[i].e_flush));
      chk($sformatf("tbl%0d_issue", i),  0, 32'(issue_o[0]),  32'(tbl[i].e_issue));
      chk($sformatf("tbl%0d_busy", i),   0, busy_o[0],        tbl[i].e_busy);
      tick();
    end

    // LOAD_LAT=3 load r7, writeback one cycle later releases the dependent
    do_reset();
    drive(1, 1, 1, 0, 0, 7, 1, 0, 0, 0);
    sample();
    chk("wb_load_issue", 1, 32'(issue_o[1]), 32'd1);
    tick();
    drive(1, 7, 1, 0, 0, 8, 0, 0, 1, 7);
    sample();
    chk("wb_dep_stall", 1, 32'(stall_o[1]), 32'd1);
    chk("wb_busy7_set", 1, 32'(busy_o[1][7]), 32'd1);
    tick();
    drive(1, 7, 1, 0, 0, 8, 0, 0, 0, 0);
    sample();
    chk("wb_busy7_clr", 1, 32'(busy_o[1][7]), 32'd0);
    chk("wb_dep_issue", 1, 32'(issue_o[1]), 32'd1);
    chk("wb_dep_issue", 2, 32'(issue_o[2]), 32'd1);
    tick();

    // watchdog: STALL_MAX=4, LOAD_LAT=7, no writeback
    do_reset();
    drive(1, 1, 1, 0, 0, 9, 1, 0, 0, 0);
    sample();
    tick();
    for (int i = 1; i <= 7; i++) begin
      drive(1, 9, 1, 0, 0, 10, 0, 0, 0, 0);
      sample();
      chk($sformatf("wd_stall%0d", i), 2, 32'(stall_o[2]), 32'd1);
      chk($sformatf("wd_err%0d", i), 2, 32'(err_o[2]), (i >= 5) ? 32'd1 : 32'd0);
      tick();
    end
    sample();
    chk("wd_release_issue", 2, 32'(issue_o[2]), 32'd1);
    tick();
    idle();
    repeat (3) begin sample(); tick(); end
    sample();
    chk("wd_err_sticky", 2, 32'(err_o[2]), 32'd1);
    chk("wd_err_other", 0, 32'(err_o[0]), 32'd0);
    tick();
    do_reset();
    sample();
    chk("wd_err_reset", 2, 32'(err_o[2]), 32'd0);
    tick();

    // stall counter: 3 stall cycles on LOAD_LAT=3
    drive(1, 1, 1, 0, 0, 7, 1, 0, 0, 0);
    sample();
    tick();
    repeat (4) begin
      drive(1, 7, 1, 0, 0, 8, 0, 0, 0, 0);
      sample();
      tick();
    end
    idle();
    sample();
    chk("perf_cnt3", 1, stcnt_o[1], PERF ? 32'd3 : 32'd0);
    tick();

    // reset in the middle of a stall drops pending state
    drive(1, 1, 1, 0, 0, 7, 1, 0, 0, 0);
    sample();
    tick();
    drive(1, 7, 1, 0, 0, 8, 0, 0, 0, 0);
    p_reset = 1'b1;
    sample();
    chk("mid_rst_stall", 1, 32'(stall_o[1]), 32'd1);
    tick();
    p_reset = 1'b0;
    sample();
    chk("post_rst_stall", 1, 32'(stall_o[1]), 32'd0);
    chk("post_rst_busy", 1, busy_o[1], 32'd0);
    chk("post_rst_issue", 1, 32'(issue_o[1]), 32'd1);
    chk("post_rst_stcnt", 1, stcnt_o[1], 32'd0);
    tick();

    // redirect flush length per FLUSH_CYC
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    sample();
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      sample();
      chk($sformatf("flush_len%0d", i), 0, 32'(flush_o[0]), (i < 1) ? 32'd1 : 32'd0);
      chk($sformatf("flush_len%0d", i), 1, 32'(flush_o[1]), (i < 3) ? 32'd1 : 32'd0);
      chk($sformatf("flush_len%0d", i), 2, 32'(flush_o[2]), (i < 2) ? 32'd1 : 32'd0);
      tick();
    end

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 40, $urandom_range(0, 11) == 0,
            $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)));
      p_reset = ($urandom_range(0, 79) == 0);
      sample();
      tick();
    end
    p_reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
